// File: rtl/fg_operand_loader_if.sv
// Bundles the sample-in, weight-write and group-out signals of fg_operand_loader.
// The loader connects through the slave modport; the producer/consumer side uses master.
interface fg_operand_loader_if #(
    parameter int unsigned W     = 19,
    parameter int unsigned NBANK = 4
);
    localparam int unsigned BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          mode;
    logic [BW-1:0] bank_sel;
    logic          w_wr_en;
    logic [BW-1:0] w_wr_bank;
    logic [1:0]    w_wr_idx;
    logic [W-1:0]  w_wr_data;
    logic [W-1:0]  a, b, c, d;
    logic [W-1:0]  wa, wb, wc, wd;
    logic          wsum_zero;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;

    modport slave (
        input  in_data, in_valid, in_last, mode, bank_sel,
        input  w_wr_en, w_wr_bank, w_wr_idx, w_wr_data, out_ready,
        output in_ready, a, b, c, d, wa, wb, wc, wd, wsum_zero, out_valid, frame_done
    );

    modport master (
        output in_data, in_valid, in_last, mode, bank_sel,
        output w_wr_en, w_wr_bank, w_wr_idx, w_wr_data, out_ready,
        input  in_ready, a, b, c, d, wa, wb, wc, wd, wsum_zero, out_valid, frame_done
    );
endinterface

// File: rtl/fg_operand_loader.sv
// Assembles 4-sample operand groups (block or sliding window) for the FG block and
// attaches the selected weight set plus a zero-weight-sum flag.
module fg_operand_loader #(
    parameter int unsigned W     = 19,
    parameter int unsigned NBANK = 4
) (
    input  logic              clk,
    input  logic              rst,
    fg_operand_loader_if.slave bus
);
    localparam int unsigned SW = W + 2;
    localparam int unsigned FW = 3;

    logic [W-1:0]  r_win  [4];
    logic [FW-1:0] r_fill;
    logic          r_mode;
    logic [W-1:0]  r_bank [NBANK][4];
    logic [W-1:0]  r_grp  [4];
    logic [W-1:0]  r_wt   [4];
    logic          r_out_valid;
    logic          r_frame_done;
    logic          r_wsum_zero;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_mode;
    logic [FW-1:0] w_fill_inc;
    logic          w_emit;
    logic          w_clear;
    logic [W-1:0]  w_shift [4];
    logic [W-1:0]  w_grp   [4];
    logic [W-1:0]  w_rd    [4];
    logic [SW-1:0] w_wsum;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_mode     = (r_fill == FW'(0)) ? bus.mode : r_mode;
    assign w_fill_inc = (r_fill == FW'(4)) ? r_fill : FW'(r_fill + FW'(1));
    assign w_emit     = w_accept && ((w_fill_inc == FW'(4)) || bus.in_last);
    // Block mode restarts after every full group; any frame end restarts both modes.
    assign w_clear    = bus.in_last || (!w_mode && (w_fill_inc == FW'(4)));

    // Window after shifting in the incoming sample, oldest at index 0.
    always_comb begin
        w_shift[0] = r_win[1];
        w_shift[1] = r_win[2];
        w_shift[2] = r_win[3];
        w_shift[3] = bus.in_data;
    end

    // Left-align short frames so a = oldest and the missing newest slots read zero.
    always_comb begin
        for (int i = 0; i < 4; i++) w_grp[i] = '0;
        case (w_fill_inc)
            FW'(1): w_grp[0] = w_shift[3];
            FW'(2): begin
                w_grp[0] = w_shift[2];
                w_grp[1] = w_shift[3];
            end
            FW'(3): begin
                w_grp[0] = w_shift[1];
                w_grp[1] = w_shift[2];
                w_grp[2] = w_shift[3];
            end
            default: for (int i = 0; i < 4; i++) w_grp[i] = w_shift[i];
        endcase
    end

    always_comb begin
        w_wsum = '0;
        for (int i = 0; i < 4; i++) begin
            w_rd[i] = r_bank[bus.bank_sel][i];
            w_wsum  = SW'(w_wsum + {{(SW-W){w_rd[i][W-1]}}, w_rd[i]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill       <= '0;
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_wsum_zero  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= '0;
                r_grp[i] <= '0;
                r_wt[i]  <= '0;
            end
            for (int b = 0; b < NBANK; b++)
                for (int i = 0; i < 4; i++) r_bank[b][i] <= '0;
        end else begin
            // Bank writes land after the read above, so an emit on this edge sees the old value.
            if (bus.w_wr_en) r_bank[bus.w_wr_bank][bus.w_wr_idx] <= bus.w_wr_data;

            if (r_fill == FW'(0)) r_mode <= bus.mode;

            if (w_accept) begin
                if (w_clear) begin
                    r_fill <= '0;
                    for (int i = 0; i < 4; i++) r_win[i] <= '0;
                end else begin
                    r_fill <= w_fill_inc;
                    for (int i = 0; i < 4; i++) r_win[i] <= w_shift[i];
                end
            end

            if (w_emit) begin
                r_out_valid  <= 1'b1;
                r_frame_done <= bus.in_last;
                r_wsum_zero  <= (w_wsum == '0);
                for (int i = 0; i < 4; i++) begin
                    r_grp[i] <= w_grp[i];
                    r_wt[i]  <= w_rd[i];
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid  <= 1'b0;
                r_frame_done <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.a          = r_grp[0];
    assign bus.b          = r_grp[1];
    assign bus.c          = r_grp[2];
    assign bus.d          = r_grp[3];
    assign bus.wa         = r_wt[0];
    assign bus.wb         = r_wt[1];
    assign bus.wc         = r_wt[2];
    assign bus.wd         = r_wt[3];
    assign bus.wsum_zero  = r_wsum_zero;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_fg_operand_loader.sv
// Directed bench for fg_operand_loader: expected groups are queued as samples are
// driven and compared when the loader hands a group off.
module tb_fg_operand_loader;
    localparam int unsigned W     = 19;
    localparam int unsigned NBANK = 4;

    typedef struct packed {
        logic [W-1:0] a, b, c, d;
        logic [W-1:0] wa, wb, wc, wd;
        logic         wz;
        logic         fd;
    } grp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    grp_t sb[$];
    grp_t g_bp;

    fg_operand_loader_if #(.W(W), .NBANK(NBANK)) bus ();

    fg_operand_loader #(.W(W), .NBANK(NBANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic grp_t obs_grp();
        grp_t g;
        g = {bus.a, bus.b, bus.c, bus.d, bus.wa, bus.wb, bus.wc, bus.wd,
             bus.wsum_zero, bus.frame_done};
        return g;
    endfunction

    function automatic grp_t mk(input int a, input int b, input int c, input int d,
                                input int wa, input int wb, input int wc, input int wd,
                                input logic wz, input logic fd);
        grp_t g;
        g = {W'(a), W'(b), W'(c), W'(d), W'(wa), W'(wb), W'(wc), W'(wd), wz, fd};
        return g;
    endfunction

    // Scoreboard: every handed-off group must match the oldest queued expectation.
    always @(negedge clk) begin
        grp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", obs_grp());
            end else begin
                e = sb.pop_front();
                chk("group", 160'(obs_grp()), 160'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input int dat, input logic last);
        int n;
        n = 0;
        bus.in_data  = W'(dat);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int bank, input int idx, input int dat);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_bank = 2'(bank);
        bus.w_wr_idx  = 2'(idx);
        bus.w_wr_data = W'(dat);
        tick();
        bus.w_wr_en   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.mode      = 1'b0;
        bus.bank_sel  = '0;
        bus.w_wr_en   = 1'b0;
        bus.w_wr_bank = '0;
        bus.w_wr_idx  = '0;
        bus.w_wr_data = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
        chk("rst_frame_done", 160'(bus.frame_done), 160'(0));
        chk("rst_wsum_zero", 160'(bus.wsum_zero), 160'(0));
        chk("rst_a", 160'(bus.a), 160'(0));
        chk("rst_wa", 160'(bus.wa), 160'(0));
        chk("rst_in_ready", 160'(bus.in_ready), 160'(1));

        // Block mode with bank0 weights
        wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 4);
        sb.push_back(mk(10, 20, 30, 40, 1, 2, 3, 4, 1'b0, 1'b0));
        send(10, 0); send(20, 0); send(30, 0);
        chk("blk_no_early_valid", 160'(bus.out_valid), 160'(0));
        send(40, 0);
        chk("blk_latency_valid", 160'(bus.out_valid), 160'(1));
        idle();
        tick(); tick();

        // Sliding mode, then a fresh fill after in_last
        bus.mode = 1'b1;
        sb.push_back(mk(1, 2, 3, 4, 1, 2, 3, 4, 1'b0, 1'b0));
        sb.push_back(mk(2, 3, 4, 5, 1, 2, 3, 4, 1'b0, 1'b0));
        sb.push_back(mk(3, 4, 5, 6, 1, 2, 3, 4, 1'b0, 1'b1));
        send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 0); send(6, 1);
        chk("sld_frame_done", 160'(bus.frame_done), 160'(1));
        idle();
        tick();
        chk("sld_frame_done_clears", 160'(bus.frame_done), 160'(0));
        sb.push_back(mk(7, 8, 9, 10, 1, 2, 3, 4, 1'b0, 1'b1));
        send(7, 0); send(8, 0); send(9, 0);
        chk("sld_refill_no_early", 160'(bus.out_valid), 160'(0));
        send(10, 1);
        idle();
        tick(); tick();
        bus.mode = 1'b0;

        // Backpressure: offered sample 99 must not enter while the group stalls
        bus.out_ready = 1'b0;
        g_bp = mk(11, 12, 13, 14, 1, 2, 3, 4, 1'b0, 1'b0);
        sb.push_back(g_bp);
        send(11, 0); send(12, 0); send(13, 0); send(14, 0);
        chk("bp_valid", 160'(bus.out_valid), 160'(1));
        bus.in_data  = W'(99);
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 160'(bus.in_ready), 160'(0));
            chk("bp_outputs_frozen", 160'(obs_grp()), 160'(g_bp));
        end
        tick();
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 160'(bus.in_ready), 160'(1));
        sb.push_back(mk(99, 15, 16, 17, 1, 2, 3, 4, 1'b0, 1'b0));
        send(99, 0); send(15, 0); send(16, 0); send(17, 0);
        idle();
        tick(); tick();

        // Partial block-mode frame is zero-padded at the newest end
        sb.push_back(mk(-7, 9, 0, 0, 1, 2, 3, 4, 1'b0, 1'b1));
        send(-7, 0); send(9, 1);
        chk("part_frame_done", 160'(bus.frame_done), 160'(1));
        idle();
        tick(); tick();

        // Zero weight sum, then a write colliding with the emit edge
        wr(1, 0, 5); wr(1, 1, -5); wr(1, 2, 0); wr(1, 3, 0);
        bus.bank_sel = 2'd1;
        sb.push_back(mk(21, 22, 23, 24, 5, -5, 0, 0, 1'b1, 1'b0));
        sb.push_back(mk(25, 26, 27, 28, 8, -5, 0, 0, 1'b0, 1'b0));
        send(21, 0); send(22, 0); send(23, 0);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_bank = 2'd1;
        bus.w_wr_idx  = 2'd0;
        bus.w_wr_data = W'(8);
        send(24, 0);
        bus.w_wr_en = 1'b0;
        chk("coll_wsum_zero", 160'(bus.wsum_zero), 160'(1));
        send(25, 0); send(26, 0); send(27, 0); send(28, 0);
        idle();
        chk("coll_new_wa", 160'(bus.wa), 160'(8));
        tick(); tick();

        // Reset with a partly filled window
        send(31, 0); send(32, 0); send(33, 0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", 160'(bus.out_valid), 160'(0));
        chk("mrst_wa", 160'(bus.wa), 160'(0));
        chk("mrst_in_ready", 160'(bus.in_ready), 160'(1));
        sb.push_back(mk(41, 42, 43, 44, 0, 0, 0, 0, 1'b1, 1'b0));
        send(41, 0); send(42, 0); send(43, 0);
        chk("mrst_no_early", 160'(bus.out_valid), 160'(0));
        send(44, 0);
        idle();
        repeat (4) tick();

        chk("sb_drained", 160'(sb.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fg_operand_loader.md
Name: fg_operand_loader

Overview:
- Upstream operand stage for the FG weighted-average block.
- Accepts a serial stream of 19-bit signed samples through a valid/ready handshake and assembles 4-sample groups that drive FG inputs a,b,c,d.
- Supplies the matching weight set wa1..wd1 from a small banked weight register file.
- Flags zero-sum weight sets so the downstream divider result can be discarded.

Parameters:
- W, 19, sample/weight width (signed two's complement)
- NBANK, 4, number of weight sets (bank index width = 2)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- in_data  in  W  sample
- in_valid  in  1  sample valid
- in_last  in  1  marks final sample of a frame, qualified by in_valid
- in_ready  out  1  loader can accept a sample
- mode  in  1  0 = block (non-overlapping groups of 4), 1 = sliding (stride 1)
- bank_sel  in  2  weight bank attached to the next emitted group
- w_wr_en  in  1  weight write strobe
- w_wr_bank  in  2  weight bank to write
- w_wr_idx  in  2  weight entry to write (0=wa, 1=wb, 2=wc, 3=wd)
- w_wr_data  in  W  weight value
- a, b, c, d  out  W  group samples, a = oldest, d = newest
- wa, wb, wc, wd  out  W  weights of the selected bank
- wsum_zero  out  1  wa+wb+wc+wd == 0 for the presented group
- out_valid  out  1  group registers hold a valid group
- out_ready  in  1  consumer accepts the group (tie high for free-running FG)
- frame_done  out  1  one-cycle pulse with the group containing in_last

Behaviour:
- Reset:
  - out_valid, frame_done, wsum_zero = 0.
  - a..d and wa..wd = 0.
  - Fill count = 0, window shift register cleared, all weight banks cleared to 0.
  - in_ready = 1 in the cycle after rst deasserts.
- Handshake:
  - Sample accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - Group handed off when out_valid && out_ready.
  - While out_valid && !out_ready, all outputs are held stable and no samples are accepted.
- Window:
  - 4-entry shift register; each accepted sample shifts in at the newest slot.
  - fill count saturates at 4.
- Mode latch: mode is sampled only when fill count == 0; a change mid-group takes effect at the next group start.
- Block mode:
  - Emission happens on the clock edge accepting the 4th sample. On that edge out_valid=1, a..d are loaded with the 4 samples, and fill returns to 0.
  - Output latency: 1 cycle after the 4th sample handshake.
- Sliding mode:
  - First emission occurs on acceptance of the 4th sample.
  - Every subsequent accepted sample emits a new group.
  - Groups overlap by 3 samples.
- in_last:
  - If fill < 4 after the last sample in block mode, emit immediately with the missing newest slots zero-filled. Example: 2 samples x,y gives a=x, b=y, c=0, d=0.
  - If fewer than 4 samples were accepted in sliding mode, pad the same way.
  - In sliding mode with a full window, emit normally.
  - After in_last, always clear the window and set fill = 0.
  - frame_done = 1 in the same cycle as out_valid for that group; it clears on handoff.
- Weights:
  - wa..wd and wsum_zero are captured from bank bank_sel on the same edge that loads a..d.
  - Write-read collision: a write to the selected bank on the emit edge is not visible in that group; the group gets the old value.
  - Writes are accepted every cycle regardless of handshake state and never stall.
- wsum_zero:
  - Computed as a 21-bit signed sum of the four captured weights.
  - Asserted when the sum equals 0, including when all weights are 0 after reset.
- Back-to-back: with out_ready=1 and in_valid held high in sliding mode, one group per cycle is emitted after fill.
- Reset mid-operation:
  - Any in-flight group is dropped and out_valid falls on the reset edge.
  - Weight banks are cleared.

Test Plan:
1. Block mode: write bank0 = {1,2,3,4}, bank_sel=0, stream 10,20,30,40 with out_ready=1. Required: one group a=10, b=20, c=30, d=40, wa..wd=1,2,3,4, wsum_zero=0, one cycle after the 4th handshake.
2. Sliding mode: stream 1..6 continuously. Required: groups (1,2,3,4), (2,3,4,5), (3,4,5,6) on consecutive cycles; fill restarts after in_last on 6, with frame_done on the last group.
3. Backpressure: out_ready=0 while a group is valid. Required: in_ready=0 and outputs frozen for 5 cycles; on out_ready=1 the handoff occurs and in_ready returns high the same cycle.
4. Partial frame: block mode, samples -7,9 with in_last on 9. Required: a=-7, b=9, c=0, d=0, frame_done=1.
5. Weight collision and zero sum:
   - bank1 = {5,-5,0,0}, bank_sel=1. Required: wsum_zero=1.
   - Write bank1 idx0 = 8 on the emit edge. Required: the group shows wa=5; the next group shows wa=8 and wsum_zero=0.
6. Reset mid-group: after 3 samples, assert rst for 1 cycle. Required: out_valid=0, weights read 0, and the next 4 samples form a fresh group.
